multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; clk is the clock port and rst_n the reset port.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 run  input  1  level; permits leaving IDLE and continuing after each instruction.
REQ-005 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-006 mem_ready  input  1  memory handshake; access completes in a cycle where it is 1.
REQ-007 pc_write, pc_write_eq, pc_write_ne, ir_write, i_or_d, mem_read, mem_write  output  1 each  PC, IR and memory strobes.
REQ-008 reg_dst, reg_write, mem_to_reg, alu_src_a  output  1 each  register-file and ALU-A select.
REQ-009 alu_src_b, alu_op, pc_source  output  2 each  ALU-B select (00 reg, 01 const 1, 10 sign-ext, 11 sign-ext shifted), ALU op (00 add, 01 sub, 10 funct), next-PC select (00 ALU, 01 ALUOut, 10 jump).
REQ-010 state  output  4  current state encoding.
REQ-011 halted  output  1  high in HALT.
REQ-012 retired  output  16  count of completed instructions.

Function
REQ-013 States and encodings SHALL be: IDLE 0, FETCH 1, DECODE 2, MEMADDR 3, MEMRD 4, MEMWB 5, MEMWR 6, REXEC 7, RWB 8, BRANCH 9, JUMP 10, IEXEC 11, IWB 12, HALT 13; codes 14-15 SHALL go to HALT.
REQ-014 IDLE -> FETCH when run=1, else stay.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready; move to DECODE only when mem_ready=1, else hold.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, no strobes; next by opcode: 000000->REXEC, 100011/101011->MEMADDR, 000100/000101->BRANCH, 001000->IEXEC, 000010->JUMP (see REQ-028), other->HALT.
REQ-017 MEMADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD if opcode=100011, else MEMWR.
REQ-018 MEMRD: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEMWB.
REQ-019 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; instruction ends.
REQ-020 MEMWR: mem_write=1, i_or_d=1; hold until mem_ready=1; instruction ends in the mem_ready cycle.
REQ-021 REXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next RWB. RWB: reg_write=1, reg_dst=1, mem_to_reg=0; instruction ends.
REQ-022 IEXEC: alu_src_a=1, alu_src_b=10, alu_op=00; next IWB. IWB: reg_write=1, reg_dst=0, mem_to_reg=0; instruction ends.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; pc_write_eq=1 if opcode=000100, pc_write_ne=1 if 000101; instruction ends.
REQ-024 On instruction end, next state SHALL be FETCH if run=1, else IDLE; retired SHALL increment by 1 in that same edge, wrapping FFFF->0000.
REQ-025 HALT SHALL be left only by reset; halted=1, all strobes 0.
REQ-026 Outputs not listed for a state SHALL be 0; all outputs are Moore functions of state except the mem_ready gating in REQ-015.
REQ-027 Latency with mem_ready=1 throughout: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3 cycles FETCH-to-FETCH.

Configuration
REQ-028 Macro MCTRL_JUMP_EN: defined -> opcode 000010 goes DECODE->JUMP, JUMP drives pc_write=1, pc_source=10, then ends instruction; undefined -> JUMP state unreachable, opcode 000010 goes to HALT.

Reset
REQ-029 rst_n=0 at a rising edge SHALL set state=IDLE and retired=0, regardless of current state, including mid-handshake.
REQ-030 pc_write, pc_write_eq, pc_write_ne, ir_write, reg_write, mem_write SHALL be forced 0 combinationally while rst_n=0.

Verification
REQ-031 run=1, mem_ready=1, opcode=100011 -> states 1,2,3,4,5,1; reg_write=1 with mem_to_reg=1 only in state 5; retired=1.
REQ-032 opcode=101011, mem_ready low 3 cycles in MEMWR -> state 6 held 4 cycles, mem_write=1 throughout, retired increments once.
REQ-033 opcode=000101 -> states 1,2,9; pc_write_ne=1, pc_write_eq=0, alu_op=01 in state 9.
REQ-034 opcode=000010 -> with MCTRL_JUMP_EN states 1,2,10,1 and pc_source=10; without it state 13, halted=1.
REQ-035 rst_n=0 while in MEMRD with mem_ready=0 -> strobes 0 that cycle, next state 0, retired=0; run=0 at RWB -> IDLE.

Source files
------------

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - run/opcode/memory handshake inputs and datapath control outputs of multicycle_control
interface multicycle_control_if;
   logic        run;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        pc_write;
   logic        pc_write_eq;
   logic        pc_write_ne;
   logic        ir_write;
   logic        i_or_d;
   logic        mem_read;
   logic        mem_write;
   logic        reg_dst;
   logic        reg_write;
   logic        mem_to_reg;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic [1:0]  pc_source;
   logic [3:0]  state;
   logic        halted;
   logic [15:0] retired;

   modport master (
      output run, opcode, mem_ready,
      input  pc_write, pc_write_eq, pc_write_ne, ir_write, i_or_d, mem_read, mem_write,
      input  reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
      input  state, halted, retired
   );

   modport slave (
      input  run, opcode, mem_ready,
      output pc_write, pc_write_eq, pc_write_ne, ir_write, i_or_d, mem_read, mem_write,
      output reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
      output state, halted, retired
   );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with retired-instruction counter
// Define MCTRL_JUMP_EN to decode opcode 000010 as a jump; otherwise it halts.
module multicycle_control (
   input logic                 clk,
   input logic                 rst_n,
   multicycle_control_if.slave bus
);
   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_FETCH   = 4'd1;
   localparam logic [3:0] S_DECODE  = 4'd2;
   localparam logic [3:0] S_MEMADDR = 4'd3;
   localparam logic [3:0] S_MEMRD   = 4'd4;
   localparam logic [3:0] S_MEMWB   = 4'd5;
   localparam logic [3:0] S_MEMWR   = 4'd6;
   localparam logic [3:0] S_REXEC   = 4'd7;
   localparam logic [3:0] S_RWB     = 4'd8;
   localparam logic [3:0] S_BRANCH  = 4'd9;
   localparam logic [3:0] S_JUMP    = 4'd10;
   localparam logic [3:0] S_IEXEC   = 4'd11;
   localparam logic [3:0] S_IWB     = 4'd12;
   localparam logic [3:0] S_HALT    = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [3:0]  state_q, state_d;
   logic [15:0] retired_q, retired_d;
   logic        instr_end;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   // Unlisted codes (including JUMP when disabled, and 14-15) fall into HALT.
   always_comb begin
      state_d   = S_HALT;
      instr_end = 1'b0;
      case (state_q)
         S_IDLE:    state_d = bus.run ? S_FETCH : S_IDLE;
         S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE:      state_d = S_REXEC;
               OP_LW, OP_SW:  state_d = S_MEMADDR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_ADDI:       state_d = S_IEXEC;
`ifdef MCTRL_JUMP_EN
               OP_J:          state_d = S_JUMP;
`endif
               default:       state_d = S_HALT;
            endcase
         end
         S_MEMADDR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR: begin
            state_d   = S_MEMWR;
            instr_end = bus.mem_ready;
         end
         S_REXEC:   state_d = S_RWB;
         S_IEXEC:   state_d = S_IWB;
         S_MEMWB, S_RWB, S_IWB, S_BRANCH: instr_end = 1'b1;
`ifdef MCTRL_JUMP_EN
         S_JUMP:    instr_end = 1'b1;
`endif
         default:   state_d = S_HALT;
      endcase
      if (instr_end) begin
         state_d = bus.run ? S_FETCH : S_IDLE;
      end
   end

   assign retired_d = retired_q + {15'd0, instr_end};

   always_comb begin
      bus.pc_write    = 1'b0;
      bus.pc_write_eq = 1'b0;
      bus.pc_write_ne = 1'b0;
      bus.ir_write    = 1'b0;
      bus.i_or_d      = 1'b0;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.reg_dst     = 1'b0;
      bus.reg_write   = 1'b0;
      bus.mem_to_reg  = 1'b0;
      bus.alu_src_a   = 1'b0;
      bus.alu_src_b   = 2'b00;
      bus.alu_op      = 2'b00;
      bus.pc_source   = 2'b00;
      case (state_q)
         S_FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            bus.ir_write  = bus.mem_ready;
            bus.pc_write  = bus.mem_ready;
         end
         S_DECODE:  bus.alu_src_b = 2'b11;
         S_MEMADDR, S_IEXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            bus.mem_read = 1'b1;
            bus.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            bus.mem_write = 1'b1;
            bus.i_or_d    = 1'b1;
         end
         S_REXEC: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = 2'b10;
         end
         S_RWB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
         end
         S_IWB:     bus.reg_write = 1'b1;
         S_BRANCH: begin
            bus.alu_src_a   = 1'b1;
            bus.alu_op      = 2'b01;
            bus.pc_source   = 2'b01;
            bus.pc_write_eq = (bus.opcode == OP_BEQ);
            bus.pc_write_ne = (bus.opcode == OP_BNE);
         end
`ifdef MCTRL_JUMP_EN
         S_JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = 2'b10;
         end
`endif
         default: ;
      endcase
      // Architectural write strobes must never fire while reset is asserted.
      if (!rst_n) begin
         bus.pc_write    = 1'b0;
         bus.pc_write_eq = 1'b0;
         bus.pc_write_ne = 1'b0;
         bus.ir_write    = 1'b0;
         bus.reg_write   = 1'b0;
         bus.mem_write   = 1'b0;
      end
   end

   assign bus.state   = state_q;
   assign bus.halted  = (state_q == S_HALT);
   assign bus.retired = retired_q;
endmodule
